// File: rtl/dpram_fifo_ctrl_if.sv
// Valid/ready streaming bundle for dpram_fifo_ctrl: push side (in_*) and pop side (out_*).
// slave = FIFO side, master = the producer/consumer environment.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FWFT streaming FIFO controller sequencing an external dpram_rw (pointers, occupancy, prefetch).
// Optional synchronous clear port `flush` is enabled by defining DPRAM_FIFO_CTRL_FLUSH_EN.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    localparam int AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_fifo_ctrl_if.slave      strm,
    output logic [AW:0]           count,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_wr_en,
    output logic [AW-1:0]         ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
    ,
    input  logic                  flush
`endif
);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DATA_DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_cnt;     // words in RAM not yet fetched into the read register
    logic          out_valid_q;
    logic          push;
    logic          fetch;
    logic          clr;

`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        count         = mem_cnt + (AW+1)'(out_valid_q);
        strm.in_ready = rst && (count < DEPTH_CNT);
        push          = strm.in_valid && strm.in_ready;
        // The read register doubles as the output stage: refill when empty or being popped.
        fetch         = (mem_cnt != '0) && (!out_valid_q || strm.out_ready);

        ram_wr_en     = push && !clr;
        ram_wr_addr   = wr_ptr;
        ram_wr_data   = strm.in_data;
        ram_rd_en     = fetch && !clr;
        ram_rd_addr   = rd_ptr;

        strm.out_valid = out_valid_q;
        strm.out_data  = ram_rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (fetch)
                rd_ptr <= rd_ptr + AW'(1);
            mem_cnt     <= mem_cnt + (AW+1)'(push) - (AW+1)'(fetch);
            out_valid_q <= fetch || (out_valid_q && !strm.out_ready);
        end
    end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural dpram_rw model and a queue reference.
module tb_dpram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_tb = 1'b0;
    logic [AW:0]   count;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_rd_data, ram_wr_data;
    logic [DW-1:0] mem [DEPTH];
`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
    logic          flush_tb = 1'b0;
`endif

    dpram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst_tb),
        .strm        (bus),
        .count       (count),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
        ,
        .flush       (flush_tb)
`endif
    );

    // dpram_rw behaviour: registered read, old data on same-address collision
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        logic [DW-1:0] d;
        int unsigned   e;
    } ent_t;

    ent_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned edge_n = 0;
    bit          push_pend = 1'b0;
    bit          flush_pend = 1'b0;
    bit          rst_cur = 1'b0;
    bit          flush_cur = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; a word is logged with the edge index at which it is accepted.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        rst_tb        = rst_cur;
`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
        flush_tb      = flush_cur;
`endif
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        if (!rst_cur) q.delete();
        push_pend  = rst_cur && v && bus.in_ready && !flush_cur;
        flush_pend = flush_cur;
        if (push_pend) q.push_back('{d: d, e: edge_n + 1});
    endtask

    // Monitor: the head word is visible from the edge after its push onward, since the
    // controller fetches whenever the output stage is free.
    initial begin
        int committed;
        int memc;
        bit ov_exp;
        forever begin
            @(negedge clk);
            #2;
            committed = q.size() - (push_pend ? 1 : 0);
            ov_exp    = (committed > 0) && (edge_n >= q[0].e + 1);
            memc      = committed - (ov_exp ? 1 : 0);
            chk("count", 32'(count), 32'(committed));
            chk("in_ready", 32'(bus.in_ready), 32'(rst_tb && committed < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(ov_exp));
            chk("ram_wr_en", 32'(ram_wr_en), 32'(push_pend));
            chk("ram_rd_en", 32'(ram_rd_en),
                32'(!flush_pend && memc > 0 && (!ov_exp || bus.out_ready)));
            if (ov_exp) chk("out_data", 32'(bus.out_data), 32'(q[0].d));
            if (flush_pend) q.delete();
            else if (ov_exp && bus.out_ready) void'(q.pop_front());
        end
    end

    initial begin
        logic [DW-1:0] seq [4];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        seq[0] = 8'hde; seq[1] = 8'had; seq[2] = 8'hbe; seq[3] = 8'hef;

        rst_cur = 1'b0;
        repeat (3) cyc(1'b1, 8'h55, 1'b1);
        chk("reset_count", 32'(count), 32'd0);
        rst_cur = 1'b1;
        cyc(1'b0, '0, 1'b0);

        // Four directed words, consumer stalled, then drained back to back
        for (int i = 0; i < 4; i++) cyc(1'b1, seq[i], 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b0);
        chk("four_count", 32'(count), 32'd4);
        repeat (6) cyc(1'b0, '0, 1'b1);
        chk("four_drained", 32'(count), 32'd0);

        // Fill to capacity, one refused push, drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, (i % 2) ? 8'ha5 : 8'h5a, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        chk("full_refused", 32'(push_pend), 32'd0);
        chk("full_count", 32'(count), 32'(DEPTH));
        repeat (DEPTH + 4) cyc(1'b0, '0, 1'b1);
        chk("full_drained", 32'(count), 32'd0);

        // Steady streaming across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b0);
        repeat (1000) cyc(1'b1, 8'($urandom), 1'b1);
        chk("stream_count", 32'(count), 32'd8);
        repeat (12) cyc(1'b0, '0, 1'b1);

        // Consumer stall with a word at the head
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        repeat (10) cyc(1'b0, '0, 1'b0);
        chk("stall_data", 32'(bus.out_data), 32'(q[0].d));
        repeat (6) cyc(1'b0, '0, 1'b1);

        // Random traffic, push-heavy then pop-heavy
        repeat (1500) cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
        repeat (1500) cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
        repeat (DEPTH + 4) cyc(1'b0, '0, 1'b1);
        chk("random_drained", 32'(count), 32'd0);

        // Reset mid-stream at count 37
        for (int i = 0; i < 37; i++) cyc(1'b1, 8'($urandom), 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd37);
        rst_cur = 1'b0;
        cyc(1'b0, '0, 1'b0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b0, '0, 1'b0);
        rst_cur = 1'b1;
        cyc(1'b1, 8'h11, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("post_reset_latency", 32'(bus.out_valid), 32'd0);
        cyc(1'b0, '0, 1'b1);
        chk("post_reset_data", 32'(bus.out_data), 32'h11);
        repeat (3) cyc(1'b0, '0, 1'b1);

`ifdef DPRAM_FIFO_CTRL_FLUSH_EN
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        flush_cur = 1'b1;
        cyc(1'b1, 8'hcc, 1'b0);
        flush_cur = 1'b0;
        cyc(1'b0, '0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (4) cyc(1'b0, '0, 1'b1);
`endif

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that sequences an external `dpram_rw` instance, turning its raw read and write ports into a valid/ready streaming FIFO. It owns the read/write pointers and the occupancy count. It prefetches one word into the RAM's read register so that the head word is presented first-word-fall-through. It sits between a producer and a consumer stage and is the standard way the team uses `dpram_rw` as a queue.

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached `dpram_rw`.
- `DATA_DEPTH`, 256, RAM depth; must be a power of two ≥ 2; `AW = $clog2(DATA_DEPTH)`.

Ports:
- `clk`  in  1  single clock; every register samples on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  FIFO accepts a word this cycle.
- `in_data`  in  DATA_WIDTH  push data.
- `out_valid`  out  1  head word is present on `out_data`.
- `out_ready`  in  1  consumer takes the head word this cycle.
- `out_data`  out  DATA_WIDTH  head word; wired directly to `ram_rd_data`.
- `count`  out  AW+1  total words held, 0..DATA_DEPTH.
- `ram_rd_en`, `ram_rd_addr[AW]`, `ram_rd_data[DATA_WIDTH]` (in)  drive or receive `dpram_rw` read port.
- `ram_wr_en`, `ram_wr_addr[AW]`, `ram_wr_data[DATA_WIDTH]`  drive `dpram_rw` write port.
- `flush`  in  1  present only with `DPRAM_FIFO_CTRL_FLUSH_EN`.

## Operation
- RAM contract: `ram_rd_data` updates on the edge where `ram_rd_en`=1 and holds otherwise. A same-address read and write in one cycle returns the old data.
- Push: `push = in_valid & in_ready`. It drives `ram_wr_en`=1, `ram_wr_addr=wr_ptr`, `ram_wr_data=in_data`. `wr_ptr` increments modulo DATA_DEPTH.
- `mem_cnt` holds the words in RAM not yet fetched. `count = mem_cnt + out_valid`.
- Fetch: `fetch = (mem_cnt != 0) & (!out_valid | out_ready)`. It drives `ram_rd_en`=1 and `ram_rd_addr=rd_ptr`. `rd_ptr` increments modulo DATA_DEPTH.
- `out_valid` next value = `fetch | (out_valid & !out_ready)`.
- Pop: `out_valid & out_ready`. When `mem_cnt`>0, a pop and a fetch occur in the same cycle, giving back-to-back throughput of 1 word/cycle.
- `in_ready = rst & (count < DATA_DEPTH)`. Pointer wrap is modulo-2^AW with no special casing.
- The fetched slot is free once fetched. It may be overwritten while its data is still held in the RAM read register, so total capacity is DATA_DEPTH.
- Simultaneous push and fetch to the same address cannot occur, because fetch only runs when `mem_cnt`≥1 at cycle start.
- Push while full is refused (`in_ready`=0). Pop while empty is a no-op.
- Push and pop in the same cycle leave `count` unchanged.

## Timing
- Reset (rst=0, async): `wr_ptr`, `rd_ptr`, `mem_cnt`, `out_valid` are cleared to 0.
  - Outputs during reset: `count`=0, `in_ready`=0, `out_valid`=0, `ram_wr_en`=0, `ram_rd_en`=0, addresses 0.
  - `out_data` is undefined until the first fetch.
- Reset asserted mid-operation discards all contents immediately. RAM contents are not cleared.
- Latency into an empty FIFO: a push at edge N makes `mem_cnt`=1, the fetch is issued in the following cycle, and `out_valid`=1 after edge N+1 (2 cycles).
- `count` updates on the push edge, 1 cycle before `out_valid` rises.
- Once asserted, `out_valid` and `out_data` hold stable until popped.

## Configuration
- `DPRAM_FIFO_CTRL_FLUSH_EN` defined: adds the `flush` input.
  - On an edge with `flush`=1, pointers, `mem_cnt` and `out_valid` clear to 0 and any push or fetch that cycle is discarded.
  - `ram_wr_en` and `ram_rd_en` are forced to 0 while `flush`=1.
  - `flush` has priority over all other activity.
- Not defined: no `flush` port; contents clear only by `rst`.

## Test plan
- Push 0xde, 0xad, 0xbe, 0xef with `out_ready`=0 -> `count`=4 and `out_valid` rises 2 cycles after the first push. Then `out_ready`=1 -> 0xde, 0xad, 0xbe, 0xef are popped on 4 consecutive cycles and `count` returns to 0.
- Fill 256 alternating 0x5a/0xa5 -> `in_ready`=0 at `count`=256 and a 257th push is refused. Then drain -> all 256 words come out in order.
- Continuous push and pop for 1000 cycles with `$random` data -> `count` stays constant, 1 word/cycle, and output matches a reference queue across pointer wrap.
- Consumer stall: hold `out_ready`=0 for 10 cycles while `out_valid`=1 -> `out_data` stays unchanged and no `ram_rd_en` pulse occurs.
- Assert `rst`=0 mid-stream with `count`=37 -> `count`=0, `out_valid`=0 and `in_ready`=0 immediately. After release, a push of 0x11 appears after 2 cycles.
- With `DPRAM_FIFO_CTRL_FLUSH_EN`: `flush` alongside a push at `count`=5 -> next cycle `count`=0, `out_valid`=0, and the pushed word is never output.
